// File: rtl/mem_err_pkg.sv
// Shared types, default parameter values and width helper for mem_error_monitor.
// Optional feature macro used by the monitor: MEM_ERR_TIMESTAMP_EN.
package mem_err_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ERROR   = 2'd2,
    FATAL   = 2'd3
  } mon_state_t;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_NUM_MEMS   = 6;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_THRESHOLD  = 3;
  localparam int DEF_TS_W       = 16;

  // Width of the flat per-row error vector covering every monitored memory.
  function automatic int flat_width(input int num_mems, input int array_size);
    return num_mems * array_size;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for the error-cycle count.
// load1 has priority over clr so a clear with a same-cycle hit restarts at 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         load1,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: load to 1, clear, or increment holding at all-ones.
  always_comb begin
    count_d = count_q;
    if (load1) begin
      count_d = W'(1);
    end else if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/mem_error_monitor.sv
// Memory error monitor: sticky flags, first-error snapshot, saturating
// error-cycle count and latched FATAL escalation with a clear handshake.
// Optional first-error timestamp enabled by defining MEM_ERR_TIMESTAMP_EN.
module mem_error_monitor
  import mem_err_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int NUM_MEMS   = DEF_NUM_MEMS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int TS_W       = DEF_TS_W
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         valid_outputs,
  input  logic [flat_width(NUM_MEMS, ARRAY_SIZE)-1:0]  mem_errors,
  input  logic                                         clear_req,
  output logic [flat_width(NUM_MEMS, ARRAY_SIZE)-1:0]  error,
  output logic [flat_width(NUM_MEMS, ARRAY_SIZE)-1:0]  first_error,
  output logic [CNT_W-1:0]                             err_count,
  output logic                                         any_error,
  output logic                                         fatal,
  output logic                                         clear_ack
`ifdef MEM_ERR_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]                              first_ts
`endif
);

  localparam int FW = flat_width(NUM_MEMS, ARRAY_SIZE);
  localparam longint unsigned MAX_CNT = (64'd1 << CNT_W) - 64'd1;
  // With a threshold of 1 the very first captured error is already fatal.
  localparam mon_state_t CAPTURE_STATE = (THRESHOLD == 1) ? FATAL : ERROR;

  if ((THRESHOLD < 1) || (THRESHOLD > MAX_CNT) || (TS_W < 1)) begin : g_bad_param
    $error("mem_error_monitor: THRESHOLD must be in 1..2^CNT_W-1 and TS_W >= 1");
  end

  mon_state_t    state_q, state_d;
  logic [FW-1:0] error_q, error_d;
  logic [FW-1:0] first_error_q, first_error_d;
  logic          any_error_q, any_error_d;
  logic          clear_ack_q, clear_ack_d;
  logic          hit;
  logic          do_clear;
  logic          capture;
  logic          cnt_inc, cnt_clr, cnt_load1;
  logic [CNT_W-1:0] cnt_next;

  assign hit = |mem_errors;

  // Next-state and register-update logic; clear is applied before a same-cycle capture.
  always_comb begin
    state_d       = state_q;
    error_d       = error_q;
    first_error_d = first_error_q;
    clear_ack_d   = clear_req;
    do_clear      = 1'b0;
    capture       = 1'b0;
    cnt_inc       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_load1     = 1'b0;

    case (state_q)
      IDLE: begin
        // Flags are ignored until the array reports valid outputs.
        if (valid_outputs) begin
          state_d = MONITOR;
        end
      end
      default: begin
        if (clear_req) begin
          do_clear      = 1'b1;
          cnt_clr       = 1'b1;
          error_d       = '0;
          first_error_d = '0;
          state_d       = MONITOR;
        end
        if (hit && (clear_req || (state_q == MONITOR))) begin
          capture       = 1'b1;
          cnt_load1     = 1'b1;
          error_d       = error_d | mem_errors;
          first_error_d = mem_errors;
          state_d       = CAPTURE_STATE;
        end else if (!clear_req && (state_q == ERROR)) begin
          error_d = error_q | mem_errors;
          if (hit) begin
            cnt_inc = 1'b1;
            if (cnt_next == CNT_W'(THRESHOLD)) begin
              state_d = FATAL;
            end
          end
        end
      end
    endcase

    any_error_d = |error_d;
  end

  // Main state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      error_q       <= '0;
      first_error_q <= '0;
      any_error_q   <= 1'b0;
      clear_ack_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      error_q       <= error_d;
      first_error_q <= first_error_d;
      any_error_q   <= any_error_d;
      clear_ack_q   <= clear_ack_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc        (cnt_inc),
    .clr        (cnt_clr),
    .load1      (cnt_load1),
    .count      (err_count),
    .count_next (cnt_next)
  );

  assign error       = error_q;
  assign first_error = first_error_q;
  assign any_error   = any_error_q;
  assign fatal       = (state_q == FATAL);
  assign clear_ack   = clear_ack_q;

`ifdef MEM_ERR_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] first_ts_q, first_ts_d;

  // Free-running cycle stamp and first-error stamp capture/clear.
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    first_ts_d = first_ts_q;
    if (do_clear) begin
      first_ts_d = '0;
    end
    if (capture) begin
      first_ts_d = ts_q;
    end
  end

  // Timestamp registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      first_ts_q <= '0;
    end else begin
      ts_q       <= ts_d;
      first_ts_q <= first_ts_d;
    end
  end

  assign first_ts = first_ts_q;
`endif

endmodule

// File: tb/tb_mem_error_monitor.sv
// Self-checking bench for mem_error_monitor (ARRAY_SIZE=4, NUM_MEMS=6, THRESHOLD=3, CNT_W=8).
module tb_mem_error_monitor;
  import mem_err_pkg::*;

  localparam int FW = 24;
  localparam int CW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_outputs = 1'b0;
  logic [FW-1:0] mem_errors = '0;
  logic          clear_req = 1'b0;
  logic [FW-1:0] error;
  logic [FW-1:0] first_error;
  logic [CW-1:0] err_count;
  logic          any_error;
  logic          fatal;
  logic          clear_ack;
`ifdef MEM_ERR_TIMESTAMP_EN
  logic [TW-1:0] first_ts;
`endif

  always #5 clk = ~clk;

  mem_error_monitor #(
    .ARRAY_SIZE (4),
    .NUM_MEMS   (6),
    .CNT_W      (CW),
    .THRESHOLD  (3),
    .TS_W       (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_outputs (valid_outputs),
    .mem_errors    (mem_errors),
    .clear_req     (clear_req),
    .error         (error),
    .first_error   (first_error),
    .err_count     (err_count),
    .any_error     (any_error),
    .fatal         (fatal),
    .clear_ack     (clear_ack)
`ifdef MEM_ERR_TIMESTAMP_EN
    ,
    .first_ts      (first_ts)
`endif
  );

  typedef struct packed {
    logic [FW-1:0] err;
    logic [FW-1:0] first;
    logic [CW-1:0] cnt;
    logic          any;
    logic          fat;
    logic          ack;
  } obs_t;

  typedef struct {
    logic          valid;
    logic [FW-1:0] mem;
    logic          clr;
    obs_t          exp;
  } row_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic row_t mk(input logic v, input logic [FW-1:0] m, input logic c,
                              input logic [FW-1:0] e, input logic [FW-1:0] f,
                              input logic [CW-1:0] n, input logic fa, input logic a);
    row_t r;
    r.valid     = v;
    r.mem       = m;
    r.clr       = c;
    r.exp.err   = e;
    r.exp.first = f;
    r.exp.cnt   = n;
    r.exp.any   = (e != '0);
    r.exp.fat   = fa;
    r.exp.ack   = a;
    return r;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.err   = error;
    o.first = first_error;
    o.cnt   = err_count;
    o.any   = any_error;
    o.fat   = fatal;
    o.ack   = clear_ack;
    return o;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, sample 1 time unit after the edge.
  task automatic drive_cycle(input row_t r);
    valid_outputs = r.valid;
    mem_errors    = r.mem;
    clear_req     = r.clr;
    sb.push_back(r.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t g;
    rst = 1'b0;
    #2;
    g = observed();
    checks++;
    if (g !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", g);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, IDLE);
    end
    #6 rst = 1'b1;
    $display("txn reset: outputs=%h", g);
  endtask

  task automatic test_idle_errors();
    row_t rows[$];
    rows.push_back(mk(0, 24'h0, 1, 24'h0, 24'h0, 0, 0, 1));
    for (int k = 0; k < 5; k++) rows.push_back(mk(0, 24'h000001, 0, 24'h0, 24'h0, 0, 0, 0));
    rows.push_back(mk(1, 24'h0, 0, 24'h0, 24'h0, 0, 0, 0));
    rows.push_back(mk(0, 24'h0, 0, 24'h0, 24'h0, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t e, g;
      drive_cycle(rows[i]);
      e = sb.pop_front();
      g = observed();
      checks++;
      $display("txn idle[%0d]: valid=%b mem=%h clr=%b -> %h", i, rows[i].valid, rows[i].mem, rows[i].clr, g);
      if (g !== e) begin
        errors++;
        $display("FAIL idle[%0d]: got %h, expected %h", i, g, e);
      end
    end
    checks++;
    if (dut.state_q !== MONITOR) begin
      errors++;
      $display("FAIL idle_arm_state: got %0d, expected %0d", dut.state_q, MONITOR);
    end
  endtask

  task automatic test_first_error();
    row_t rows[$];
    rows.push_back(mk(0, 24'h000010, 0, 24'h000010, 24'h000010, 1, 0, 0));
    rows.push_back(mk(0, 24'h100000, 0, 24'h100010, 24'h000010, 2, 0, 0));
    rows.push_back(mk(0, 24'h000000, 0, 24'h100010, 24'h000010, 2, 0, 0));
    foreach (rows[i]) begin
      obs_t e, g;
      drive_cycle(rows[i]);
      e = sb.pop_front();
      g = observed();
      checks++;
      $display("txn first_error[%0d]: mem=%h -> %h", i, rows[i].mem, g);
      if (g !== e) begin
        errors++;
        $display("FAIL first_error[%0d]: got %h, expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_threshold();
    row_t rows[$];
    rows.push_back(mk(0, 24'h000001, 0, 24'h100011, 24'h000010, 3, 1, 0));
    rows.push_back(mk(0, 24'h800000, 0, 24'h100011, 24'h000010, 3, 1, 0));
    rows.push_back(mk(1, 24'h000000, 0, 24'h100011, 24'h000010, 3, 1, 0));
    foreach (rows[i]) begin
      obs_t e, g;
      drive_cycle(rows[i]);
      e = sb.pop_front();
      g = observed();
      checks++;
      $display("txn threshold[%0d]: mem=%h -> %h", i, rows[i].mem, g);
      if (g !== e) begin
        errors++;
        $display("FAIL threshold[%0d]: got %h, expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_clear_hit();
    row_t rows[$];
    rows.push_back(mk(0, 24'h000100, 1, 24'h000100, 24'h000100, 1, 0, 1));
    rows.push_back(mk(0, 24'h000000, 0, 24'h000100, 24'h000100, 1, 0, 0));
    foreach (rows[i]) begin
      obs_t e, g;
      drive_cycle(rows[i]);
      e = sb.pop_front();
      g = observed();
      checks++;
      $display("txn clear_hit[%0d]: mem=%h clr=%b -> %h", i, rows[i].mem, rows[i].clr, g);
      if (g !== e) begin
        errors++;
        $display("FAIL clear_hit[%0d]: got %h, expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    rows.push_back(mk(0, 24'h0, 1, 24'h0, 24'h0, 0, 0, 1));
    rows.push_back(mk(0, 24'h0, 1, 24'h0, 24'h0, 0, 0, 1));
    rows.push_back(mk(0, 24'h0, 0, 24'h0, 24'h0, 0, 0, 0));
    rows.push_back(mk(0, 24'h000002, 0, 24'h000002, 24'h000002, 1, 0, 0));
    rows.push_back(mk(0, 24'h000002, 0, 24'h000002, 24'h000002, 2, 0, 0));
    rows.push_back(mk(0, 24'h000004, 0, 24'h000006, 24'h000002, 3, 1, 0));
    foreach (rows[i]) begin
      obs_t e, g;
      drive_cycle(rows[i]);
      e = sb.pop_front();
      g = observed();
      checks++;
      $display("txn back_to_back[%0d]: mem=%h clr=%b -> %h", i, rows[i].mem, rows[i].clr, g);
      if (g !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h, expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t pre[$];
    row_t post[$];
    obs_t g;
    pre.push_back(mk(0, 24'h0, 1, 24'h0, 24'h0, 0, 0, 1));
    pre.push_back(mk(0, 24'h000008, 0, 24'h000008, 24'h000008, 1, 0, 0));
    foreach (pre[i]) begin
      obs_t e, o;
      drive_cycle(pre[i]);
      e = sb.pop_front();
      o = observed();
      checks++;
      $display("txn async_pre[%0d]: mem=%h clr=%b -> %h", i, pre[i].mem, pre[i].clr, o);
      if (o !== e) begin
        errors++;
        $display("FAIL async_pre[%0d]: got %h, expected %h", i, o, e);
      end
    end
    #2 rst = 1'b0;
    #1;
    g = observed();
    checks++;
    $display("txn async_reset: outputs=%h", g);
    if (g !== obs_t'(0)) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, expected 0", g);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL async_reset_state: got %0d, expected %0d", dut.state_q, IDLE);
    end
    #2 rst = 1'b1;
    post.push_back(mk(0, 24'h000001, 0, 24'h0, 24'h0, 0, 0, 0));
    post.push_back(mk(1, 24'h000000, 0, 24'h0, 24'h0, 0, 0, 0));
    post.push_back(mk(0, 24'h000040, 0, 24'h000040, 24'h000040, 1, 0, 0));
    foreach (post[i]) begin
      obs_t e, o;
      drive_cycle(post[i]);
      e = sb.pop_front();
      o = observed();
      checks++;
      $display("txn async_post[%0d]: valid=%b mem=%h -> %h", i, post[i].valid, post[i].mem, o);
      if (o !== e) begin
        errors++;
        $display("FAIL async_post[%0d]: got %h, expected %h", i, o, e);
      end
    end
  endtask

`ifdef MEM_ERR_TIMESTAMP_EN
  task automatic test_timestamp();
    row_t rows[$];
    rst = 1'b0;
    #2 rst = 1'b1;
    rows.push_back(mk(1, 24'h0, 0, 24'h0, 24'h0, 0, 0, 0));
    for (int k = 0; k < 38; k++) rows.push_back(mk(0, 24'h0, 0, 24'h0, 24'h0, 0, 0, 0));
    rows.push_back(mk(0, 24'h000001, 0, 24'h000001, 24'h000001, 1, 0, 0));
    foreach (rows[i]) begin
      obs_t e, g;
      drive_cycle(rows[i]);
      e = sb.pop_front();
      g = observed();
      if (rows[i].mem != '0) begin
        checks++;
        $display("txn ts_hit[%0d]: mem=%h -> %h ts=%0d", i, rows[i].mem, g, first_ts);
        if (g !== e) begin
          errors++;
          $display("FAIL ts_hit_outputs: got %h, expected %h", g, e);
        end
      end
    end
    checks++;
    if (first_ts !== TW'(39)) begin
      errors++;
      $display("FAIL ts_capture: got %0d, expected 39", first_ts);
    end
    drive_cycle(mk(0, 24'h0, 1, 24'h0, 24'h0, 0, 0, 1));
    begin
      obs_t e, g;
      e = sb.pop_front();
      g = observed();
      checks++;
      $display("txn ts_clear: -> %h ts=%0d", g, first_ts);
      if (g !== e) begin
        errors++;
        $display("FAIL ts_clear_outputs: got %h, expected %h", g, e);
      end
      checks++;
      if (first_ts !== TW'(0)) begin
        errors++;
        $display("FAIL ts_clear: got %0d, expected 0", first_ts);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_errors();
    test_first_error();
    test_threshold();
    test_clear_hit();
    test_back_to_back();
    test_async_reset();
`ifdef MEM_ERR_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_error_monitor.md
Name: mem_error_monitor

Overview:
- Parametrised successor to the fixed six-memory error detector. Monitors NUM_MEMS x ARRAY_SIZE per-row memory error flags after the array first produces valid outputs.
- Keeps sticky flags, a first-error snapshot and a saturating error-cycle counter. Escalates to a latched FATAL state at a programmable threshold.
- Supports software clear via a req/ack pulse handshake.
- Sits between the LABFT memory checkers and the top-level status/interrupt logic.

Parameters:
- ARRAY_SIZE, 4, rows per memory.
- NUM_MEMS, 6, number of monitored memories.
- CNT_W, 8, error-cycle counter width.
- THRESHOLD, 3, error-cycle count that forces FATAL. Legal range 1..2^CNT_W-1; elaboration error otherwise.
- TS_W, 16, timestamp width; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_outputs  in  1  array outputs valid; arms monitoring.
- mem_errors  in  NUM_MEMS*ARRAY_SIZE  raw error flags, memory m at bits [m*ARRAY_SIZE +: ARRAY_SIZE].
- clear_req  in  1  single-cycle clear request.
- error  out  NUM_MEMS*ARRAY_SIZE  sticky OR of all captured flags.
- first_error  out  NUM_MEMS*ARRAY_SIZE  flag vector of the first erroneous cycle since reset/clear.
- err_count  out  CNT_W  cycles with any flag set, saturating.
- any_error  out  1  OR-reduction of error.
- fatal  out  1  high while in FATAL.
- clear_ack  out  1  one-cycle pulse acknowledging clear_req.
- first_ts  out  TS_W  cycle stamp of first error; only with MEM_ERR_TIMESTAMP_EN.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, timestamp counter 0.
- All outputs are registered. Flags sampled at edge k appear on outputs after edge k; latency is 1 cycle.
- "hit" means |mem_errors in the current cycle.
- IDLE:
  - mem_errors ignored.
  - valid_outputs=1 -> MONITOR.
- MONITOR:
  - hit -> error|=flags, first_error<=flags, err_count<=1.
  - Next state FATAL if THRESHOLD==1, else ERROR.
  - No hit -> stay.
- ERROR:
  - error|=flags each cycle. first_error frozen.
  - hit -> err_count+1, saturating at all-ones.
  - FATAL when the updated count reaches THRESHOLD.
- FATAL:
  - error, first_error and err_count frozen; new flags are not accumulated.
  - fatal=1.
- valid_outputs is ignored outside IDLE; deasserting it never returns the block to IDLE.
- Clear:
  - clear_req in any state produces clear_ack=1 on the next cycle.
  - In MONITOR/ERROR/FATAL: error, first_error, err_count and first_ts are zeroed and state goes to MONITOR.
  - In IDLE: ack only, no state change.
- Clear with a simultaneous hit uses clear-then-capture. Same-cycle flags are loaded as a fresh first error: error=first_error=flags, err_count=1, next state ERROR (or FATAL if THRESHOLD==1). No error is lost.
- Back-to-back clear_req: each cycle's request is acked. clear_ack is clear_req delayed by one cycle.
- Counter saturation applies only when THRESHOLD exceeds the reachable count. It cannot wrap.
- Reset asserted mid-operation returns every output to 0 immediately, independent of clk.

Optional Feature:
- Macro MEM_ERR_TIMESTAMP_EN.
- With it:
  - A free-running TS_W-bit cycle counter starts at 0 on reset release and wraps modulo 2^TS_W.
  - first_ts captures the counter value on the cycle first_error is loaded.
  - first_ts is cleared by clear and frozen otherwise.
- Without it: the first_ts port and the counter are absent.

Decomposition:
- Package mem_err_pkg holds:
  - state enum mon_state_t {IDLE=0, MONITOR, ERROR, FATAL}, 2 bits;
  - default parameter constants;
  - a function computing the flat vector width NUM_MEMS*ARRAY_SIZE.
- Sub-module sat_counter #(W), with inc/clr/load1 inputs, implements err_count.
- Sticky, snapshot and timestamp registers stay inline, using the team's async-reset flop style.

Test Plan (ARRAY_SIZE=4, NUM_MEMS=6, THRESHOLD=3, CNT_W=8):
- Errors in IDLE: mem_errors=24'h000001 with valid_outputs=0 for 5 cycles -> error=0, err_count=0. Then valid_outputs=1 -> state MONITOR.
- First error: in MONITOR drive 24'h000010, then 24'h100000 -> first_error=24'h000010, error=24'h100010, err_count=2, fatal=0.
- Threshold: a third hit of 24'h000001 -> err_count=3, fatal=1. Further hit 24'h800000 -> error unchanged at 24'h100011.
- Clear with simultaneous hit: in FATAL drive clear_req=1 and mem_errors=24'h000100 -> next cycle clear_ack=1, error=first_error=24'h000100, err_count=1, fatal=0.
- Async reset: assert rst=0 mid-ERROR between clock edges -> all outputs 0 immediately. After release, the block needs valid_outputs to re-arm.
- With MEM_ERR_TIMESTAMP_EN: first hit at the 40th cycle after reset release -> first_ts=39. Clear -> first_ts=0.
